// File: rtl/vx_commit_arb.sv
// vx_commit_arb: round-robin, packet-atomic arbiter merging NUM_REQS
// execution-unit commit streams into one registered commit stream.
// Optional build macro VX_COMMIT_ARB_PERF_EN adds saturating stall and
// lock-duration performance counters (perf_stall_cycles, perf_lock_cycles).

`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef LOG2UP
`define LOG2UP(x) (((x) > 1) ? $clog2(x) : 1)
`endif
`ifndef RRS_WIS_W
`define RRS_WIS_W 2
`endif
`ifndef UUID_WIDTH
`define UUID_WIDTH 44
`endif
`ifndef NW_BITS
`define NW_BITS 2
`endif
`ifndef NR_BITS
`define NR_BITS 5
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef PERF_CTR_BITS
`define PERF_CTR_BITS 44
`endif

module vx_commit_arb #(
    parameter int NUM_REQS  = 4,
    parameter int NUM_LANES = `NUM_THREADS,
    parameter int PID_WIDTH = `LOG2UP(`NUM_THREADS / NUM_LANES),
    parameter int RRS_W     = `RRS_WIS_W,
    parameter int UUID_W    = `UUID_WIDTH,
    parameter int NW_W      = `NW_BITS,
    parameter int NR_W      = `NR_BITS,
    parameter int XLEN_W    = `XLEN,
    // uuid, wid, tmask, PC, wb, rd, data, pid, sop, eop, rrs_id (MSB -> LSB)
    localparam int DATA_W   = UUID_W + NW_W + NUM_LANES + XLEN_W + 1 + NR_W
                              + NUM_LANES * XLEN_W + PID_WIDTH + 2 + RRS_W,
    localparam int SEL_W    = `LOG2UP(NUM_REQS)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_REQS-1:0]          in_valid,
    input  logic [NUM_REQS*DATA_W-1:0]   in_data,
    output logic [NUM_REQS-1:0]          in_ready,
    output logic                         out_valid,
    output logic [DATA_W-1:0]            out_data,
    input  logic                         out_ready,
    output logic [SEL_W-1:0]             out_sel
`ifdef VX_COMMIT_ARB_PERF_EN
    ,
    output logic [`PERF_CTR_BITS-1:0]    perf_stall_cycles,
    output logic [`PERF_CTR_BITS-1:0]    perf_lock_cycles
`endif
);

    // Position of the end-of-packet flag inside one payload.
    localparam int EOP_BIT = RRS_W;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    lock_state_t       state_p1;
    lock_state_t       state_next;
    logic [SEL_W-1:0]  locked_idx_p1;
    logic [SEL_W-1:0]  locked_idx_next;
    logic [SEL_W-1:0]  rr_ptr_p1;

    logic              vld_p1;
    logic [DATA_W-1:0] data_p1;
    logic [SEL_W-1:0]  sel_p1;

    logic [DATA_W-1:0] req_data [NUM_REQS];
    logic              en;
    logic              grant_found;
    logic [SEL_W-1:0]  grant_idx;
    logic [DATA_W-1:0] grant_data;
    logic              grant_eop;
    logic              xfer;
    logic [SEL_W-1:0]  ptr_after;

    // Round-robin pick: first valid requester at or above ptr, wrapping.
    // Iterating from the farthest offset down lets the nearest one win.
    function automatic logic [SEL_W:0] rr_pick(input logic [NUM_REQS-1:0] valid,
                                               input logic [SEL_W-1:0]    ptr);
        logic [SEL_W:0] pick;
        int             idx;
        pick = '0;
        for (int k = NUM_REQS - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_REQS;
            if (valid[SEL_W'(idx)]) begin
                pick = {1'b1, SEL_W'(idx)};
            end
        end
        return pick;
    endfunction

    for (genvar i = 0; i < NUM_REQS; i++) begin : g_slice
        assign req_data[i] = in_data[i*DATA_W +: DATA_W];
    end

    // The output register can take a new packet when empty or draining.
    assign en         = !vld_p1 || out_ready;
    assign grant_data = req_data[grant_idx];
    assign grant_eop  = grant_data[EOP_BIT];
    assign xfer       = en && grant_found;
    assign ptr_after  = (grant_idx == SEL_W'(NUM_REQS - 1)) ? '0 : grant_idx + 1'b1;

    // Grant selection: a lock pins the grant to the owner, even when it is idle.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        if (state_p1 == LOCKED) begin
            grant_idx   = locked_idx_p1;
            grant_found = in_valid[locked_idx_p1];
        end else begin
            {grant_found, grant_idx} = rr_pick(in_valid, rr_ptr_p1);
        end
    end

    // Accept is one-hot on the granted requester, and never while in reset.
    always_comb begin
        in_ready = '0;
        if (reset_n && xfer) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    // Lock state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_p1      <= UNLOCKED;
            locked_idx_p1 <= '0;
        end else begin
            state_p1      <= state_next;
            locked_idx_p1 <= locked_idx_next;
        end
    end

    // Lock next-state: a slice without eop opens a lock, the owner's eop closes it.
    always_comb begin
        state_next      = state_p1;
        locked_idx_next = locked_idx_p1;
        case (state_p1)
            UNLOCKED: begin
                if (xfer && !grant_eop) begin
                    state_next      = LOCKED;
                    locked_idx_next = grant_idx;
                end
            end
            LOCKED: begin
                if (xfer && grant_eop) begin
                    state_next = UNLOCKED;
                end
            end
            default: state_next = UNLOCKED;
        endcase
    end

    // Fairness pointer moves past a requester only when its packet completes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_p1 <= '0;
        end else if (xfer && grant_eop) begin
            rr_ptr_p1 <= ptr_after;
        end
    end

    // Output stage: load on transfer, empty on idle drain, hold on stall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            sel_p1  <= '0;
        end else if (en) begin
            vld_p1 <= grant_found;
            if (grant_found) begin
                data_p1 <= grant_data;
                sel_p1  <= grant_idx;
            end
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = data_p1;
    assign out_sel   = sel_p1;

`ifdef VX_COMMIT_ARB_PERF_EN
    localparam int PERF_W = `PERF_CTR_BITS;

    logic [PERF_W-1:0] stall_cnt_p1;
    logic [PERF_W-1:0] lock_cnt_p1;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Count cycles where someone wants to commit but nothing moves, and lock cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_p1 <= '0;
            lock_cnt_p1  <= '0;
        end else begin
            if ((|in_valid) && !(|(in_valid & in_ready))) begin
                stall_cnt_p1 <= sat_inc(stall_cnt_p1);
            end
            if (state_p1 == LOCKED) begin
                lock_cnt_p1 <= sat_inc(lock_cnt_p1);
            end
        end
    end

    assign perf_stall_cycles = stall_cnt_p1;
    assign perf_lock_cycles  = lock_cnt_p1;
`else
    // Performance counters are not built in this configuration.
`endif

endmodule
